// File: rtl/mole_hit_scorer_pkg.sv
// Shared definitions for the whack-a-mole hit scorer: FSM encoding, sizes and
// saturating counter helpers.
package mole_hit_scorer_pkg;

    localparam int NUM_POS = 8;
    localparam int SCORE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        UP    = 2'd1,
        FLASH = 2'd2
    } state_e;

    function automatic logic [SCORE_W-1:0] satInc(input logic [SCORE_W-1:0] v);
        return (v == {SCORE_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [SCORE_W-1:0] satDec(input logic [SCORE_W-1:0] v);
        return (v == {SCORE_W{1'b0}}) ? v : v - 1'b1;
    endfunction

endpackage

// File: rtl/mole_hit_scorer_timer.sv
// Loadable up-counter with a terminal-count flag; used for the mole lifetime
// and for the hit-confirm flash.
module mole_timer #(
    parameter int                WIDTH    = 8,
    parameter logic [WIDTH-1:0]  TERMINAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load wins over counting so a new phase always starts from a known value.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == TERMINAL);

endmodule

// File: rtl/mole_hit_scorer.sv
// Whack-a-mole hit scorer: shows one mole, scores hits, counts timeouts as misses.
// Optional macro WRONG_HIT_PENALTY_EN adds a score penalty for stray hits.
module mole_hit_scorer
    import mole_hit_scorer_pkg::*;
#(
    parameter int LIFETIME_CYCLES = 100000000,
    parameter int FLASH_CYCLES    = 25000000
) (
    input  logic         CLK100MHZ,
    input  logic         CPU_RESETN,
    input  logic         game_en,
    input  logic [7:0]   positionhit,
    input  logic         spawn_valid,
    input  logic [2:0]   spawn_pos,
    output logic         spawn_ready,
    output logic [7:0]   mole_leds,
    output logic [7:0]   score,
    output logic [7:0]   miss_count,
    output logic         hit_pulse,
    output logic         miss_pulse
);

    localparam int MAX_CYC = (LIFETIME_CYCLES > FLASH_CYCLES) ? LIFETIME_CYCLES : FLASH_CYCLES;
    localparam int TIMER_W = $clog2(MAX_CYC);

    state_e               state_q, state_d;
    logic [2:0]           pos_q, pos_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SCORE_W-1:0]   missCount_q, missCount_d;
    logic                 hitPulse_q, hitPulse_d;
    logic                 missPulse_q, missPulse_d;
    logic                 armed_q;
    logic                 lifeLoad, lifeTc;
    logic                 flashLoad, flashTc;
    logic                 correctHit;
    logic [NUM_POS-1:0]   moleOnehot;

    assign moleOnehot = NUM_POS'(1) << pos_q;
    assign correctHit = (state_q == UP) && positionhit[pos_q];
    // armed_q keeps spawn_ready low for the first cycle after reset release.
    assign spawn_ready = (state_q == IDLE) && game_en && armed_q;

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        score_d     = score_q;
        missCount_d = missCount_q;
        hitPulse_d  = 1'b0;
        missPulse_d = 1'b0;
        lifeLoad    = 1'b0;
        flashLoad   = 1'b0;
        if (!game_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (spawn_valid && spawn_ready) begin
                        pos_d    = spawn_pos;
                        lifeLoad = 1'b1;
                        state_d  = UP;
                    end
                end
                UP: begin
                    // A hit on the last lifetime cycle still counts as a hit.
                    if (correctHit) begin
                        state_d    = FLASH;
                        flashLoad  = 1'b1;
                        hitPulse_d = 1'b1;
                        score_d    = satInc(score_q);
                    end else if (lifeTc) begin
                        state_d     = IDLE;
                        missPulse_d = 1'b1;
                        missCount_d = satInc(missCount_q);
                    end
                end
                FLASH: begin
                    if (flashTc) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
`ifdef WRONG_HIT_PENALTY_EN
            if (!correctHit &&
                |(positionhit & ~((state_q == UP) ? moleOnehot : {NUM_POS{1'b0}}))) begin
                score_d     = satDec(score_q);
                missPulse_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q     <= IDLE;
            pos_q       <= '0;
            score_q     <= '0;
            missCount_q <= '0;
            hitPulse_q  <= 1'b0;
            missPulse_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            score_q     <= score_d;
            missCount_q <= missCount_d;
            hitPulse_q  <= hitPulse_d;
            missPulse_q <= missPulse_d;
            armed_q     <= 1'b1;
        end
    end

    mole_timer #(
        .WIDTH    (TIMER_W),
        .TERMINAL (TIMER_W'(LIFETIME_CYCLES - 1))
    ) uLifeTimer (
        .clk_i      (CLK100MHZ),
        .rst_ni     (CPU_RESETN),
        .load_i     (lifeLoad),
        .load_val_i ({TIMER_W{1'b0}}),
        .en_i       (state_q == UP),
        .tc_o       (lifeTc)
    );

    mole_timer #(
        .WIDTH    (TIMER_W),
        .TERMINAL (TIMER_W'(FLASH_CYCLES - 1))
    ) uFlashTimer (
        .clk_i      (CLK100MHZ),
        .rst_ni     (CPU_RESETN),
        .load_i     (flashLoad),
        .load_val_i ({TIMER_W{1'b0}}),
        .en_i       (state_q == FLASH),
        .tc_o       (flashTc)
    );

    assign mole_leds  = (state_q == UP)    ? moleOnehot :
                        (state_q == FLASH) ? 8'hFF      : 8'h00;
    assign score      = score_q;
    assign miss_count = missCount_q;
    assign hit_pulse  = hitPulse_q;
    assign miss_pulse = missPulse_q;

endmodule

// File: tb/tb_mole_hit_scorer.sv
// Self-checking bench for mole_hit_scorer (LIFETIME_CYCLES=16, FLASH_CYCLES=4);
// honours WRONG_HIT_PENALTY_EN when the macro is defined.
module tb_mole_hit_scorer;

    localparam int L = 16;
    localparam int F = 4;

    logic       CLK100MHZ = 1'b0;
    logic       CPU_RESETN = 1'b1;
    logic       game_en = 1'b0;
    logic [7:0] positionhit = 8'h00;
    logic       spawn_valid = 1'b0;
    logic [2:0] spawn_pos = 3'd0;
    logic       spawn_ready;
    logic [7:0] mole_leds;
    logic [7:0] score;
    logic [7:0] miss_count;
    logic       hit_pulse;
    logic       miss_pulse;

    int assertCount = 0;
    int failCount = 0;

    // Reference model: mode 0 idle, 1 mole up, 2 flashing; countdowns of cycles left.
    int mMode = 0;
    int mPos = 0;
    int mLeft = 0;
    int mFlash = 0;
    int mScore = 0;
    int mMisses = 0;
    int mHitP = 0;
    int mMissP = 0;
    bit mArmed = 1'b0;

    typedef struct {
        logic       en;
        logic       sv;
        logic [2:0] sp;
        logic [7:0] ph;
        logic [7:0] expLeds;
        logic       expHit;
        logic [7:0] expScore;
        logic       expReady;
    } vec_t;

    vec_t vecs[11];

    always #5 CLK100MHZ = ~CLK100MHZ;

    mole_hit_scorer #(
        .LIFETIME_CYCLES (L),
        .FLASH_CYCLES    (F)
    ) dut (
        .CLK100MHZ   (CLK100MHZ),
        .CPU_RESETN  (CPU_RESETN),
        .game_en     (game_en),
        .positionhit (positionhit),
        .spawn_valid (spawn_valid),
        .spawn_pos   (spawn_pos),
        .spawn_ready (spawn_ready),
        .mole_leds   (mole_leds),
        .score       (score),
        .miss_count  (miss_count),
        .hit_pulse   (hit_pulse),
        .miss_pulse  (miss_pulse)
    );

    function automatic bit modelReady(input logic en);
        return (mMode == 0) && en && mArmed;
    endfunction

    function automatic logic [7:0] modelLeds();
        if (mMode == 1) return 8'(1 << mPos);
        if (mMode == 2) return 8'hFF;
        return 8'h00;
    endfunction

    task automatic modelReset();
        mMode = 0; mPos = 0; mLeft = 0; mFlash = 0;
        mScore = 0; mMisses = 0; mHitP = 0; mMissP = 0; mArmed = 1'b0;
    endtask

    task automatic modelStep(input logic en, input logic sv, input logic [2:0] sp,
                             input logic [7:0] ph);
        bit ready;
        bit correct;
        int oldMode;
        int oldPos;
        ready   = modelReady(en);
        oldMode = mMode;
        oldPos  = mPos;
        correct = (mMode == 1) && ph[mPos];
        mHitP   = 0;
        mMissP  = 0;
        if (!en) begin
            mMode = 0;
        end else if (mMode == 0) begin
            if (sv && ready) begin
                mMode = 1; mPos = int'(sp); mLeft = L;
            end
        end else if (mMode == 1) begin
            if (correct) begin
                mMode = 2; mFlash = F; mHitP = 1;
                mScore = (mScore < 255) ? mScore + 1 : 255;
            end else begin
                mLeft = mLeft - 1;
                if (mLeft == 0) begin
                    mMode = 0; mMissP = 1;
                    mMisses = (mMisses < 255) ? mMisses + 1 : 255;
                end
            end
        end else begin
            mFlash = mFlash - 1;
            if (mFlash == 0) mMode = 0;
        end
`ifdef WRONG_HIT_PENALTY_EN
        if (en && !correct) begin
            logic [7:0] allowed;
            allowed = (oldMode == 1) ? 8'(1 << oldPos) : 8'h00;
            if ((ph & ~allowed) != 8'h00) begin
                mScore = (mScore > 0) ? mScore - 1 : 0;
                mMissP = 1;
            end
        end
`else
        if (oldMode < 0 || oldPos < 0) mMode = 0;
`endif
        mArmed = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, check the combinational ready, clock, check the registers.
    task automatic applyStimulus(input logic en, input logic sv, input logic [2:0] sp,
                                 input logic [7:0] ph);
        game_en = en; spawn_valid = sv; spawn_pos = sp; positionhit = ph;
        #1;
        checkOutput("readyPre", 32'(spawn_ready), 32'(modelReady(en)));
        @(posedge CLK100MHZ);
        modelStep(en, sv, sp, ph);
        @(negedge CLK100MHZ);
        checkOutput("leds", 32'(mole_leds), 32'(modelLeds()));
        checkOutput("score", 32'(score), 32'(mScore));
        checkOutput("missCount", 32'(miss_count), 32'(mMisses));
        checkOutput("hitPulse", 32'(hit_pulse), 32'(mHitP));
        checkOutput("missPulse", 32'(miss_pulse), 32'(mMissP));
        checkOutput("readyPost", 32'(spawn_ready), 32'(modelReady(en)));
    endtask

    task automatic pulseReset();
        CPU_RESETN = 1'b0;
        #1;
        checkOutput("rstLeds", 32'(mole_leds), 32'h0);
        checkOutput("rstScore", 32'(score), 32'h0);
        checkOutput("rstMiss", 32'(miss_count), 32'h0);
        checkOutput("rstHit", 32'(hit_pulse), 32'h0);
        checkOutput("rstMissPulse", 32'(miss_pulse), 32'h0);
        checkOutput("rstReady", 32'(spawn_ready), 32'h0);
        game_en = 1'b0; spawn_valid = 1'b0; positionhit = 8'h00;
        @(negedge CLK100MHZ);
        @(negedge CLK100MHZ);
        CPU_RESETN = 1'b1;
        modelReset();
    endtask

    initial begin
        logic [7:0] heldScore;
        logic [2:0] p;
        vecs[0] = '{1'b1, 1'b1, 3'd3, 8'h00, 8'h08, 1'b0, 8'd0, 1'b0};
        for (int i = 1; i <= 4; i++) vecs[i] = '{1'b1, 1'b0, 3'd0, 8'h00, 8'h08, 1'b0, 8'd0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 3'd0, 8'h08, 8'hFF, 1'b1, 8'd1, 1'b0};
        for (int i = 6; i <= 8; i++) vecs[i] = '{1'b1, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b0, 8'd1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'd1, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'd1, 1'b1};

        #2;
        pulseReset();
        applyStimulus(1'b1, 1'b0, 3'd0, 8'h00);

        // Hit on the fifth UP cycle, then four flash cycles.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].en, vecs[i].sv, vecs[i].sp, vecs[i].ph);
            checkOutput($sformatf("vec%0d.leds", i), 32'(mole_leds), 32'(vecs[i].expLeds));
            checkOutput($sformatf("vec%0d.hit", i), 32'(hit_pulse), 32'(vecs[i].expHit));
            checkOutput($sformatf("vec%0d.score", i), 32'(score), 32'(vecs[i].expScore));
            checkOutput($sformatf("vec%0d.ready", i), 32'(spawn_ready), 32'(vecs[i].expReady));
        end

        // Timeout: 16 UP cycles without a hit.
        applyStimulus(1'b1, 1'b1, 3'd6, 8'h00);
        checkOutput("missSeq.leds", 32'(mole_leds), 32'h40);
        for (int i = 1; i < L; i++) applyStimulus(1'b1, 1'b0, 3'd0, 8'h00);
        checkOutput("missSeq.noPulseYet", 32'(miss_pulse), 32'h0);
        applyStimulus(1'b1, 1'b0, 3'd0, 8'h00);
        checkOutput("missSeq.pulse", 32'(miss_pulse), 32'h1);
        checkOutput("missSeq.count", 32'(miss_count), 32'h1);
        checkOutput("missSeq.leds0", 32'(mole_leds), 32'h0);
        checkOutput("missSeq.ready", 32'(spawn_ready), 32'h1);

        // Hit on the very cycle the lifetime runs out.
        applyStimulus(1'b1, 1'b1, 3'd1, 8'h00);
        for (int i = 1; i < L; i++) applyStimulus(1'b1, 1'b0, 3'd0, 8'h00);
        applyStimulus(1'b1, 1'b0, 3'd0, 8'h02);
        checkOutput("edgeHit.hit", 32'(hit_pulse), 32'h1);
        checkOutput("edgeHit.miss", 32'(miss_pulse), 32'h0);
        checkOutput("edgeHit.score", 32'(score), 32'd2);
        checkOutput("edgeHit.missCount", 32'(miss_count), 32'd1);
        for (int i = 0; i < F; i++) applyStimulus(1'b1, 1'b0, 3'd0, 8'h00);
        checkOutput("edgeHit.leds0", 32'(mole_leds), 32'h0);

        // Drive score to saturation.
        for (int n = 0; n < 253; n++) begin
            p = 3'($urandom_range(0, 7));
            applyStimulus(1'b1, 1'b1, p, 8'h00);
            applyStimulus(1'b1, 1'b0, 3'd0, 8'(1 << p));
            for (int i = 0; i < F; i++) applyStimulus(1'b1, 1'b0, 3'd0, 8'h00);
        end
        checkOutput("sat.score255", 32'(score), 32'd255);
        applyStimulus(1'b1, 1'b1, 3'd5, 8'h00);
        applyStimulus(1'b1, 1'b0, 3'd0, 8'h20);
        checkOutput("sat.hit", 32'(hit_pulse), 32'h1);
        checkOutput("sat.hold", 32'(score), 32'd255);
        for (int i = 0; i < F; i++) applyStimulus(1'b1, 1'b0, 3'd0, 8'h00);
`ifdef WRONG_HIT_PENALTY_EN
        applyStimulus(1'b1, 1'b1, 3'd2, 8'h00);
        applyStimulus(1'b1, 1'b0, 3'd0, 8'h01);
        checkOutput("penalty.score", 32'(score), 32'd254);
        checkOutput("penalty.missPulse", 32'(miss_pulse), 32'h1);
        checkOutput("penalty.leds", 32'(mole_leds), 32'h04);
`endif

        // game_en dropped while a mole is up.
        applyStimulus(1'b1, 1'b1, 3'd5, 8'h00);
        applyStimulus(1'b1, 1'b0, 3'd0, 8'h00);
        heldScore = score;
        applyStimulus(1'b0, 1'b0, 3'd0, 8'h20);
        checkOutput("gameOff.leds", 32'(mole_leds), 32'h0);
        checkOutput("gameOff.hit", 32'(hit_pulse), 32'h0);
        checkOutput("gameOff.miss", 32'(miss_pulse), 32'h0);
        checkOutput("gameOff.score", 32'(score), 32'(heldScore));
        checkOutput("gameOff.missCount", 32'(miss_count), 32'd1);

        // Reset while flashing, then spawn_ready held low for one cycle.
        applyStimulus(1'b1, 1'b1, 3'd4, 8'h00);
        applyStimulus(1'b1, 1'b0, 3'd0, 8'h10);
        applyStimulus(1'b1, 1'b0, 3'd0, 8'h00);
        checkOutput("preRst.leds", 32'(mole_leds), 32'hFF);
        pulseReset();
        game_en = 1'b1;
        #1;
        checkOutput("relReady0", 32'(spawn_ready), 32'h0);
        applyStimulus(1'b1, 1'b1, 3'd0, 8'h00);
        checkOutput("relReady1", 32'(spawn_ready), 32'h1);
        checkOutput("relNoSpawn", 32'(mole_leds), 32'h0);

        // Random play against the reference model.
        for (int c = 0; c < 600; c++) begin
            logic en;
            logic [7:0] ph;
            int r;
            en = ($urandom_range(0, 19) != 0);
            r  = int'($urandom_range(0, 9));
            ph = 8'h00;
            if (r < 3 && mMode == 1) ph = 8'(1 << mPos);
            else if (r == 3) ph = 8'(1 << $urandom_range(0, 7));
            applyStimulus(en, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ph);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
